// File: rtl/adapt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adapt_seq_ctrl
//
// Sequencer for an adaptive FIR datapath built around an NTAP-deep, 14-bit
// sample shift register. For every accepted input sample it:
//   1. issues a single shift strobe (with the sample and a frame-head marker)
//      together with an accumulator clear,
//   2. steps the MAC through taps 0..NTAP-1 (filter phase),
//   3. optionally steps the weight-update engine through taps 0..NTAP-1, when
//      adapt_en is high on the last filter tap,
//   4. presents out_valid until the consumer takes the result with out_ready.
// Only one sample is in flight at a time; in_ready is high only when idle.
//
// Ports
//   clk, rstn          rising-edge clock, asynchronous active-low reset
//   sample_in/in_valid/in_ready
//                      input sample handshake (accepted only when idle)
//   frame_start        pulse: the next accepted sample is a frame head
//   adapt_en           selects the weight-update phase after filtering
//   abort              cancels the current sequence, back to idle next cycle
//   shift_data_state   one-cycle shift enable to the tap register
//   shift_data         sample driven to the tap register (held between accepts)
//   head_flag          frame-head marker, valid with shift_data_state
//   tap_idx            tap index during filter / update, 0 otherwise
//   mac_clr, mac_en, upd_en
//                      accumulator clear, MAC step, weight-update step
//   out_valid/out_ready
//                      result handshake
//   busy               high whenever the sequencer is not idle
//   sample_cnt         number of completed samples, wraps at 16 bits
//
// Every output is a flop. The output values for the next cycle are derived
// from the next state, so each strobe lines up exactly with the state it
// belongs to without a one-cycle lag.
//
// NTAP must be in 1..64 so that every tap index fits in tap_idx.
// -----------------------------------------------------------------------------
module adapt_seq_ctrl #(
  parameter int NTAP = 33
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [13:0] sample_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        frame_start,
  input  logic        adapt_en,
  input  logic        abort,
  output logic        shift_data_state,
  output logic [13:0] shift_data,
  output logic        head_flag,
  output logic [5:0]  tap_idx,
  output logic        mac_clr,
  output logic        mac_en,
  output logic        upd_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] sample_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_FILT  = 3'd2,
    ST_UPD   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam logic [5:0] TAP_LAST = 6'(NTAP - 1);

  // Sequencer state and datapath registers
  state_t      state_r;
  logic [5:0]  tap_r;
  logic [13:0] data_r;
  logic [15:0] cnt_r;
  logic        pend_r;

  // Registered strobes
  logic        ready_r;
  logic        busy_r;
  logic        shift_r;
  logic        clr_r;
  logic        head_r;
  logic        mac_r;
  logic        upd_r;
  logic        ovalid_r;

  // Next-state values
  state_t      state_nx_s;
  logic [5:0]  tap_nx_s;
  logic [13:0] data_nx_s;
  logic [15:0] cnt_nx_s;
  logic        pend_nx_s;
  logic        accept_s;

  // Next values of the registered strobes
  logic        ready_nx_s;
  logic        busy_nx_s;
  logic        shift_nx_s;
  logic        clr_nx_s;
  logic        head_nx_s;
  logic        mac_nx_s;
  logic        upd_nx_s;
  logic        ovalid_nx_s;

  // A sample is taken only while idle; in_ready mirrors the idle state.
  assign accept_s = (state_r == ST_IDLE) && in_valid;

  // Next-state, tap counter, sample latch, completion counter and head pending
  always_comb begin
    state_nx_s = state_r;
    tap_nx_s   = 6'd0;
    data_nx_s  = data_r;
    cnt_nx_s   = cnt_r;
    // frame_start arms the head marker in any state; the accept below
    // consumes it (including a pulse on the accept cycle itself).
    pend_nx_s  = pend_r | frame_start;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx_s = ST_SHIFT;
          data_nx_s  = sample_in;
          pend_nx_s  = 1'b0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      // The shift strobe is already on the wire during this cycle, so abort
      // here only stops the rest of the sequence.
      ST_SHIFT: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FILT;
        end
      end

      ST_FILT: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (tap_r == TAP_LAST) begin
          // adapt_en is only looked at on the last filter tap.
          if (adapt_en) begin
            state_nx_s = ST_UPD;
          end else begin
            state_nx_s = ST_OUT;
          end
        end else begin
          state_nx_s = ST_FILT;
          tap_nx_s   = tap_r + 6'd1;
        end
      end

      ST_UPD: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (tap_r == TAP_LAST) begin
          state_nx_s = ST_OUT;
        end else begin
          state_nx_s = ST_UPD;
          tap_nx_s   = tap_r + 6'd1;
        end
      end

      // abort wins over a simultaneous out_ready: the result is dropped and
      // not counted.
      ST_OUT: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (out_ready) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = cnt_r + 16'd1;
        end else begin
          state_nx_s = ST_OUT;
        end
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the next state
  always_comb begin
    ready_nx_s  = (state_nx_s == ST_IDLE);
    busy_nx_s   = (state_nx_s != ST_IDLE);
    shift_nx_s  = (state_nx_s == ST_SHIFT);
    clr_nx_s    = (state_nx_s == ST_SHIFT);
    mac_nx_s    = (state_nx_s == ST_FILT);
    upd_nx_s    = (state_nx_s == ST_UPD);
    ovalid_nx_s = (state_nx_s == ST_OUT);
    if (accept_s) begin
      head_nx_s = pend_r | frame_start;
    end else begin
      head_nx_s = 1'b0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_IDLE;
      tap_r    <= 6'd0;
      data_r   <= 14'd0;
      cnt_r    <= 16'd0;
      pend_r   <= 1'b1;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      shift_r  <= 1'b0;
      clr_r    <= 1'b0;
      head_r   <= 1'b0;
      mac_r    <= 1'b0;
      upd_r    <= 1'b0;
      ovalid_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      tap_r    <= tap_nx_s;
      data_r   <= data_nx_s;
      cnt_r    <= cnt_nx_s;
      pend_r   <= pend_nx_s;
      ready_r  <= ready_nx_s;
      busy_r   <= busy_nx_s;
      shift_r  <= shift_nx_s;
      clr_r    <= clr_nx_s;
      head_r   <= head_nx_s;
      mac_r    <= mac_nx_s;
      upd_r    <= upd_nx_s;
      ovalid_r <= ovalid_nx_s;
    end
  end

  assign in_ready         = ready_r;
  assign busy             = busy_r;
  assign shift_data_state = shift_r;
  assign shift_data       = data_r;
  assign head_flag        = head_r;
  assign tap_idx          = tap_r;
  assign mac_clr          = clr_r;
  assign mac_en           = mac_r;
  assign upd_en           = upd_r;
  assign out_valid        = ovalid_r;
  assign sample_cnt       = cnt_r;

endmodule

// File: tb/tb_adapt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adapt_seq_ctrl
//
// Self-checking bench for adapt_seq_ctrl (NTAP = 33).
// A transaction-level reference model tracks, for the sample in flight, how
// many cycles have passed since it was accepted and derives every expected
// output from the latency rules (shift at +1, MAC at +2..+NTAP+1, update at
// +NTAP+2..+2*NTAP+1, result from +2*NTAP+2 or +NTAP+2). All outputs are
// compared against it every cycle. A table of directed transactions adds
// hand-derived per-transaction expectations; random traffic, counter wrap and
// asynchronous reset in the update phase follow.
// -----------------------------------------------------------------------------
module tb_adapt_seq_ctrl;

  localparam int NTAP = 33;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] sample_in;
  logic        in_valid;
  logic        in_ready;
  logic        frame_start;
  logic        adapt_en;
  logic        abort;
  logic        shift_data_state;
  logic [13:0] shift_data;
  logic        head_flag;
  logic [5:0]  tap_idx;
  logic        mac_clr;
  logic        mac_en;
  logic        upd_en;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] sample_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_active;
  int          m_k;
  bit          m_upd;
  bit          m_pend;
  bit          m_head;
  logic [13:0] m_data;
  logic [15:0] m_cnt;

  typedef struct {
    logic [13:0] data;
    bit          adapt_base;
    bit          adapt_last;
    int          fs_at;
    int          rdy_from;
    int          abort_at;
    bit          exp_head;
    int          exp_first_out;
    int          exp_mac;
    int          exp_upd;
    int          exp_outn;
    logic [15:0] exp_cnt;
  } row_t;

  row_t rows [13];

  always #5 clk = ~clk;

  adapt_seq_ctrl #(.NTAP(NTAP)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .sample_in        (sample_in),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .frame_start      (frame_start),
    .adapt_en         (adapt_en),
    .abort            (abort),
    .shift_data_state (shift_data_state),
    .shift_data       (shift_data),
    .head_flag        (head_flag),
    .tap_idx          (tap_idx),
    .mac_clr          (mac_clr),
    .mac_en           (mac_en),
    .upd_en           (upd_en),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .sample_cnt       (sample_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [43:0] dut_vec();
    return {in_ready, busy, shift_data_state, mac_clr, head_flag, mac_en,
            upd_en, out_valid, tap_idx, shift_data, sample_cnt};
  endfunction

  function automatic logic [43:0] model_vec();
    int         os;
    bit         sh;
    bit         mac;
    bit         upd;
    bit         ov;
    logic [5:0] tp;
    os  = m_upd ? (2 * NTAP + 2) : (NTAP + 2);
    sh  = m_active && (m_k == 1);
    mac = m_active && (m_k >= 2) && (m_k <= NTAP + 1);
    upd = m_active && m_upd && (m_k >= NTAP + 2) && (m_k <= 2 * NTAP + 1);
    ov  = m_active && (m_k >= os);
    tp  = mac ? 6'(m_k - 2) : (upd ? 6'(m_k - NTAP - 2) : 6'd0);
    return {!m_active, m_active, sh, sh, sh & m_head, mac, upd, ov, tp, m_data, m_cnt};
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_upd    = 1'b0;
    m_pend   = 1'b1;
    m_head   = 1'b0;
    m_data   = 14'd0;
    m_cnt    = 16'd0;
  endtask

  task automatic check_cycle();
    chk("cycle", {20'd0, dut_vec()}, {20'd0, model_vec()});
  endtask

  // One clock: the model consumes the inputs seen at the edge, then outputs
  // are compared 1 time unit after the edge.
  task automatic step();
    int os;
    @(posedge clk);
    if (m_active) begin
      os = m_upd ? (2 * NTAP + 2) : (NTAP + 2);
      if (abort) begin
        m_active = 1'b0;
      end else if ((m_k >= os) && out_ready) begin
        m_active = 1'b0;
        m_cnt    = m_cnt + 16'd1;
      end else begin
        if (m_k == NTAP + 1) m_upd = adapt_en;
        m_k++;
      end
      m_pend = m_pend | frame_start;
    end else if (in_valid) begin
      m_active = 1'b1;
      m_k      = 1;
      m_upd    = 1'b0;
      m_data   = sample_in;
      m_head   = m_pend | frame_start;
      m_pend   = 1'b0;
    end else begin
      m_pend = m_pend | frame_start;
    end
    #1;
    check_cycle();
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    sample_in   = 14'd0;
    frame_start = 1'b0;
    adapt_en    = 1'b0;
    abort       = 1'b0;
    out_ready   = 1'b1;
  endtask

  task automatic drive_row(input row_t r, input int c);
    // in_valid stays high with junk data while busy: nothing may be taken.
    in_valid    = 1'b1;
    sample_in   = (c == 0) ? r.data : 14'($urandom_range(0, 16383));
    frame_start = (c == r.fs_at);
    abort       = (c == r.abort_at);
    adapt_en    = (c == NTAP + 1) ? r.adapt_last : r.adapt_base;
    out_ready   = (c >= r.rdy_from);
  endtask

  task automatic run_row(input row_t r, input string nm);
    int c;
    bit hd;
    int first;
    int nmac;
    int nupd;
    int nout;
    c = 0; hd = 1'b0; first = 0; nmac = 0; nupd = 0; nout = 0;
    drive_row(r, c);
    step();
    c = 1;
    hd = head_flag;
    while (1) begin
      if (mac_en) nmac++;
      if (upd_en) nupd++;
      if (out_valid) begin
        nout++;
        if (first == 0) first = c;
      end
      if (!m_active || c >= 400) break;
      drive_row(r, c);
      step();
      c++;
    end
    idle_inputs();
    step();
    chk({nm, ".head"},      64'(hd),        64'(r.exp_head));
    chk({nm, ".first_out"}, 64'(first),     64'(r.exp_first_out));
    chk({nm, ".mac_n"},     64'(nmac),      64'(r.exp_mac));
    chk({nm, ".upd_n"},     64'(nupd),      64'(r.exp_upd));
    chk({nm, ".out_n"},     64'(nout),      64'(r.exp_outn));
    chk({nm, ".cnt"},       64'(sample_cnt), 64'(r.exp_cnt));
    chk({nm, ".data"},      64'(shift_data), 64'(r.data));
  endtask

  initial begin
    //            data     ab    al    fs  rdy  abt  head first mac upd outn cnt
    rows[0]  = '{14'h1ABC, 1'b1, 1'b1, -1,  0,  -1, 1'b1, 68, 33, 33, 1,  16'd1};
    rows[1]  = '{14'h0555, 1'b0, 1'b0, -1,  0,  -1, 1'b0, 35, 33,  0, 1,  16'd2};
    rows[2]  = '{14'h2AAA, 1'b0, 1'b0, -1, 45,  -1, 1'b0, 35, 33,  0, 11, 16'd3};
    rows[3]  = '{14'h3FFF, 1'b1, 1'b1,  5,  0,  -1, 1'b0, 68, 33, 33, 1,  16'd4};
    rows[4]  = '{14'h0001, 1'b0, 1'b0, -1,  0,  -1, 1'b1, 35, 33,  0, 1,  16'd5};
    rows[5]  = '{14'h1234, 1'b1, 1'b1, -1,  0,  12, 1'b0,  0, 11,  0, 0,  16'd5};
    rows[6]  = '{14'h0F0F, 1'b0, 1'b0,  0,  0,  -1, 1'b1, 35, 33,  0, 1,  16'd6};
    rows[7]  = '{14'h2222, 1'b0, 1'b0,  1,  0,  -1, 1'b0, 35, 33,  0, 1,  16'd7};
    rows[8]  = '{14'h3333, 1'b1, 1'b1, -1,  0,   1, 1'b1,  0,  0,  0, 0,  16'd7};
    rows[9]  = '{14'h0444, 1'b0, 1'b0, -1,  0,  -1, 1'b0, 35, 33,  0, 1,  16'd8};
    rows[10] = '{14'h1555, 1'b0, 1'b0, -1,  0,  35, 1'b0, 35, 33,  0, 1,  16'd8};
    rows[11] = '{14'h2666, 1'b1, 1'b0, -1,  0,  -1, 1'b0, 35, 33,  0, 1,  16'd9};
    rows[12] = '{14'h3777, 1'b0, 1'b1, -1,  0,  -1, 1'b0, 68, 33, 33, 1,  16'd10};

    // Reset
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    chk("reset_state", {20'd0, dut_vec()}, {20'd0, 1'b1, 43'd0});
    check_cycle();

    // Directed transactions
    foreach (rows[i]) run_row(rows[i], $sformatf("row%0d", i));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 2) != 0);
      sample_in   = 14'($urandom_range(0, 16383));
      frame_start = ($urandom_range(0, 15) == 0);
      adapt_en    = ($urandom_range(0, 1) == 1);
      abort       = ($urandom_range(0, 199) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
    end

    // Back to idle, then preload the counter to 0xFFFF and check the wrap
    idle_inputs();
    abort = 1'b1;
    step();
    idle_inputs();
    step();
    force dut.cnt_r = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.cnt_r;
    step();
    begin
      row_t w;
      w = '{14'h1111, 1'b0, 1'b0, 0, 0, -1, 1'b1, 35, 33, 0, 1, 16'h0000};
      run_row(w, "wrap");
    end

    // Asynchronous reset in the middle of the update phase
    in_valid  = 1'b1;
    sample_in = 14'h2DB6;
    adapt_en  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (40) step();
    chk("pre_reset_upd", 64'(upd_en), 64'd1);
    #2 rstn = 1'b0;
    #1;
    // in_ready is excluded here: only its value after release is defined
    chk("reset_mid_upd", {20'd0, dut_vec() & {1'b0, {43{1'b1}}}}, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    idle_inputs();
    step();
    begin
      row_t p;
      p = '{14'h0ACE, 1'b1, 1'b1, -1, 0, -1, 1'b1, 68, 33, 33, 1, 16'd1};
      run_row(p, "post_reset");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
